// File: rtl/aes_axil_pkg.sv
// Shared definitions for the AES AXI4-Lite register block.
// Contents: response code, register count, write/read FSM state types.
package aes_axil_pkg;

   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam int         NUM_REGS  = 4;

   typedef enum logic [1:0] {
      W_IDLE,
      W_GOT_ADDR,
      W_GOT_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/aes_axil_regs_if.sv
// AXI4-Lite bus bundle for the AES register block.
// master modport: drives AW/W/AR channels and BREADY/RREADY.
// slave modport : drives the READYs on AW/W/AR and the B/R channels.
interface aes_axil_regs_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
   );
endinterface

// File: rtl/aes_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit control registers to AES user logic.
// Ports:
//   ACLK        - single rising-edge clock
//   ARESETN     - asynchronous active-low reset
//   s_axi       - AXI4-Lite slave bundle (aes_axil_regs_if.slave)
//   regs_o      - register contents, reg0 in [31:0] .. reg3 in [127:96]
//   wr_pulse_o  - one-cycle strobe per register, raised with the new value
// Build option: define AES_AXIL_REGS_WSTRB_EN to honour WSTRB byte lanes;
// otherwise every write replaces the full word.
module aes_axil_regs
   import aes_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                                   ACLK,
   input  logic                                   ARESETN,
   aes_axil_regs_if.slave                         s_axi,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]                    wr_pulse_o
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;

   wr_state_t     wr_state, wr_next;
   rd_state_t     rd_state, rd_next;
   logic          rdy_en;
   logic [DW-1:0] regs_q [NUM_REGS];
   logic [1:0]    awsel_q;
   logic [DW-1:0] wdata_q;
   logic [SW-1:0] wstrb_q;
   logic          aw_hs, w_hs, ar_hs;
   logic          commit;
   logic [1:0]    commit_sel;
   logic [DW-1:0] commit_data;
   logic [SW-1:0] commit_strb;
   logic [SW-1:0] wr_mask;
   logic [DW-1:0] rdata_p0;
   logic          unused_bits;

   function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [SW-1:0] strb);
      logic [DW-1:0] merged;
      merged = old_w;
      for (int b = 0; b < SW; b++)
         if (strb[b]) merged[8*b +: 8] = new_w[8*b +: 8];
      return merged;
   endfunction

`ifdef AES_AXIL_REGS_WSTRB_EN
   assign wr_mask     = commit_strb;
   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
`else
   assign wr_mask     = '1;
   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], commit_strb};
`endif

   assign aw_hs = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
   assign w_hs  = s_axi.S_AXI_WVALID  & s_axi.S_AXI_WREADY;
   assign ar_hs = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;

   assign s_axi.S_AXI_BRESP = RESP_OKAY;
   assign s_axi.S_AXI_RRESP = RESP_OKAY;
   assign s_axi.S_AXI_RDATA = rdata_p0;

   // Holds all READYs low while in reset and releases them one edge later.
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) rdy_en <= 1'b0;
      else          rdy_en <= 1'b1;

   // ---- write FSM: state register ----
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) wr_state <= W_IDLE;
      else          wr_state <= wr_next;

   // ---- write FSM: next state ----
   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) wr_next = W_RESP;
            else if (aw_hs)    wr_next = W_GOT_ADDR;
            else if (w_hs)     wr_next = W_GOT_DATA;
         end
         W_GOT_ADDR: if (w_hs)                wr_next = W_RESP;
         W_GOT_DATA: if (aw_hs)               wr_next = W_RESP;
         W_RESP:     if (s_axi.S_AXI_BREADY)  wr_next = W_IDLE;
         default:                             wr_next = W_IDLE;
      endcase
   end

   // ---- write FSM: outputs ----
   // The commit takes the half already buffered plus the half arriving now.
   always_comb begin
      s_axi.S_AXI_AWREADY = 1'b0;
      s_axi.S_AXI_WREADY  = 1'b0;
      s_axi.S_AXI_BVALID  = 1'b0;
      commit      = 1'b0;
      commit_sel  = s_axi.S_AXI_AWADDR[3:2];
      commit_data = s_axi.S_AXI_WDATA;
      commit_strb = s_axi.S_AXI_WSTRB;
      case (wr_state)
         W_IDLE: begin
            s_axi.S_AXI_AWREADY = rdy_en;
            s_axi.S_AXI_WREADY  = rdy_en;
            commit              = aw_hs & w_hs;
         end
         W_GOT_ADDR: begin
            s_axi.S_AXI_WREADY = 1'b1;
            commit             = w_hs;
            commit_sel         = awsel_q;
         end
         W_GOT_DATA: begin
            s_axi.S_AXI_AWREADY = 1'b1;
            commit              = aw_hs;
            commit_data         = wdata_q;
            commit_strb         = wstrb_q;
         end
         W_RESP:  s_axi.S_AXI_BVALID = 1'b1;
         default: ;
      endcase
   end

   // Buffers for whichever write half arrives first; cleared by reset.
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         awsel_q <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         if (aw_hs) awsel_q <= s_axi.S_AXI_AWADDR[3:2];
         if (w_hs) begin
            wdata_q <= s_axi.S_AXI_WDATA;
            wstrb_q <= s_axi.S_AXI_WSTRB;
         end
      end

   // ---- register file and write strobes ----
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_pulse_o <= '0;
      end else begin
         if (commit)
            regs_q[commit_sel] <= merge_lanes(regs_q[commit_sel], commit_data, wr_mask);
         for (int i = 0; i < NUM_REGS; i++)
            wr_pulse_o[i] <= commit && (commit_sel == 2'(i));
      end

   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) regs_o[i*DW +: DW] = regs_q[i];
   end

   // ---- read FSM: state register ----
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) rd_state <= R_IDLE;
      else          rd_state <= rd_next;

   // ---- read FSM: next state ----
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs)               rd_next = R_DATA;
         R_DATA:  if (s_axi.S_AXI_RREADY)  rd_next = R_IDLE;
         default:                          rd_next = R_IDLE;
      endcase
   end

   // ---- read FSM: outputs ----
   always_comb begin
      s_axi.S_AXI_ARREADY = (rd_state == R_IDLE) && rdy_en;
      s_axi.S_AXI_RVALID  = (rd_state == R_DATA);
   end

   // ---- read data stage ----
   // Samples regs_q before any same-edge commit lands, so a colliding read
   // returns the old value.
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN)   rdata_p0 <= '0;
      else if (ar_hs) rdata_p0 <= regs_q[s_axi.S_AXI_ARADDR[3:2]];

endmodule

// File: tb/tb_aes_axil_regs.sv
// Directed self-checking bench for aes_axil_regs.
module tb_aes_axil_regs;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [127:0] regs_o;
   logic [3:0]   wr_pulse_o;
   int checks = 0;
   int failures = 0;

   aes_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();

   aes_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .ACLK(clk), .ARESETN(rst_n), .s_axi(axi.slave),
      .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int  n;
      logic aw_f, w_f;
      axi.S_AXI_AWADDR = a; axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WDATA  = d; axi.S_AXI_WSTRB   = s; axi.S_AXI_WVALID = 1'b1;
      axi.S_AXI_BREADY = 1'b1;
      n = 0;
      while ((axi.S_AXI_AWVALID || axi.S_AXI_WVALID) && n < 20) begin
         aw_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
         w_f  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
         tick();
         if (aw_f) axi.S_AXI_AWVALID = 1'b0;
         if (w_f)  axi.S_AXI_WVALID  = 1'b0;
         n++;
      end
      while (!axi.S_AXI_BVALID && n < 20) begin tick(); n++; end
      check1("wr_bvalid", axi.S_AXI_BVALID, 1'b1);
      check32("wr_bresp", {30'd0, axi.S_AXI_BRESP}, 32'd0);
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
      tick();
   endtask

   task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
      int  n;
      logic f;
      axi.S_AXI_ARADDR = a; axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_RREADY = 1'b1;
      n = 0;
      while (axi.S_AXI_ARVALID && n < 20) begin
         f = axi.S_AXI_ARREADY;
         tick();
         if (f) axi.S_AXI_ARVALID = 1'b0;
         n++;
      end
      while (!axi.S_AXI_RVALID && n < 20) begin tick(); n++; end
      check1("rd_rvalid", axi.S_AXI_RVALID, 1'b1);
      d = axi.S_AXI_RDATA;
      r = axi.S_AXI_RRESP;
      axi.S_AXI_ARVALID = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [31:0] exp_strb;
      int bcnt, pcnt, other, bad_b, bad_aw;

      axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
      axi.S_AXI_BREADY = 1'b1;
      axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_RREADY = 1'b1;

      // Reset state
      repeat (3) tick();
      check128("rst_regs", regs_o, 128'd0);
      check32("rst_pulse", {28'd0, wr_pulse_o}, 32'd0);
      check32("rst_rdata", axi.S_AXI_RDATA, 32'd0);
      check32("rst_valids_resps", {26'd0, axi.S_AXI_BVALID, axi.S_AXI_RVALID,
              axi.S_AXI_BRESP, axi.S_AXI_RRESP}, 32'd0);
      check32("rst_readys", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd0);
      rst_n = 1'b1;
      tick();
      check32("post_rst_readys", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd7);

      // Four writes and readback
      do_write(4'h0, 32'h1, 4'hF);
      do_write(4'h4, 32'h2, 4'hF);
      do_write(4'h8, 32'h3, 4'hF);
      do_write(4'hC, 32'h4, 4'hF);
      do_read(4'h0, rd, rr); check32("rd_reg0", rd, 32'h1); check32("rresp0", {30'd0, rr}, 32'd0);
      do_read(4'h4, rd, rr); check32("rd_reg1", rd, 32'h2); check32("rresp1", {30'd0, rr}, 32'd0);
      do_read(4'h8, rd, rr); check32("rd_reg2", rd, 32'h3); check32("rresp2", {30'd0, rr}, 32'd0);
      do_read(4'hC, rd, rr); check32("rd_reg3", rd, 32'h4); check32("rresp3", {30'd0, rr}, 32'd0);
      check128("regs_o_all", regs_o, 128'h00000004_00000003_00000002_00000001);

      // W three cycles ahead of AW
      axi.S_AXI_WDATA = 32'hDEADBEEF; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
      tick();
      axi.S_AXI_WVALID = 1'b0;
      check1("w_first_wready_low", axi.S_AXI_WREADY, 1'b0);
      check1("w_first_awready_high", axi.S_AXI_AWREADY, 1'b1);
      check1("w_first_no_bvalid", axi.S_AXI_BVALID, 1'b0);
      tick(); tick();
      axi.S_AXI_AWADDR = 4'h8; axi.S_AXI_AWVALID = 1'b1;
      bcnt = 0; pcnt = 0; other = 0;
      for (int i = 0; i < 10; i++) begin
         logic f;
         f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
         tick();
         if (f) axi.S_AXI_AWVALID = 1'b0;
         if (axi.S_AXI_BVALID) begin
            if (bcnt == 0) check32("commit_with_bvalid", regs_o[95:64], 32'hDEADBEEF);
            bcnt++;
         end
         if (wr_pulse_o == 4'b0100) pcnt++;
         else if (wr_pulse_o != 4'b0000) other++;
      end
      check32("late_aw_bresp_count", bcnt, 32'd1);
      check32("late_aw_pulse_count", pcnt, 32'd1);
      check32("late_aw_other_pulse", other, 32'd0);
      check32("late_aw_reg2", regs_o[95:64], 32'hDEADBEEF);

      // B channel stall
      axi.S_AXI_BREADY = 1'b0;
      axi.S_AXI_AWADDR = 4'h0; axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WDATA = 32'hA5A5A5A5; axi.S_AXI_WVALID = 1'b1;
      tick();
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
      check1("stall_bvalid", axi.S_AXI_BVALID, 1'b1);
      check32("stall_reg0", regs_o[31:0], 32'hA5A5A5A5);
      axi.S_AXI_AWADDR = 4'hC; axi.S_AXI_AWVALID = 1'b1;
      bad_b = 0; bad_aw = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!axi.S_AXI_BVALID) bad_b++;
         if (axi.S_AXI_AWREADY) bad_aw++;
      end
      check32("stall_bvalid_held", bad_b, 32'd0);
      check32("stall_awready_low", bad_aw, 32'd0);
      do_read(4'h8, rd, rr);
      check32("read_during_b_stall", rd, 32'hDEADBEEF);
      check1("stall_bvalid_after_read", axi.S_AXI_BVALID, 1'b1);
      check1("stall_aw_not_taken", axi.S_AXI_AWREADY, 1'b0);
      axi.S_AXI_BREADY = 1'b1;
      tick();
      check1("b_done_bvalid_low", axi.S_AXI_BVALID, 1'b0);
      check1("b_done_awready", axi.S_AXI_AWREADY, 1'b1);
      tick();
      axi.S_AXI_AWVALID = 1'b0;
      check1("new_aw_taken", axi.S_AXI_AWREADY, 1'b0);
      axi.S_AXI_WDATA = 32'h77; axi.S_AXI_WVALID = 1'b1;
      tick();
      axi.S_AXI_WVALID = 1'b0;
      check1("new_aw_bvalid", axi.S_AXI_BVALID, 1'b1);
      check32("new_aw_reg3", regs_o[127:96], 32'h77);
      tick();

      // Byte strobes
      do_write(4'h4, 32'h11223344, 4'hF);
      do_write(4'h4, 32'hAABBCCDD, 4'b0101);
`ifdef AES_AXIL_REGS_WSTRB_EN
      exp_strb = 32'h11BB33DD;
`else
      exp_strb = 32'hAABBCCDD;
`endif
      check32("wstrb_reg1", regs_o[63:32], exp_strb);

      // Read colliding with a commit to the same register
      do_write(4'h4, 32'h2, 4'hF);
      axi.S_AXI_AWADDR = 4'h4; axi.S_AXI_AWVALID = 1'b1;
      tick();
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
      axi.S_AXI_ARADDR = 4'h4; axi.S_AXI_ARVALID = 1'b1;
      check32("coll_readys", {30'd0, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd3);
      tick();
      axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
      check32("coll_valids", {30'd0, axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 32'd3);
      check32("coll_old_rdata", axi.S_AXI_RDATA, 32'h2);
      check32("coll_reg1_new", regs_o[63:32], 32'h55);
      tick();
      do_read(4'h4, rd, rr);
      check32("coll_next_read", rd, 32'h55);

      // Reset between AW and W
      axi.S_AXI_AWADDR = 4'h0; axi.S_AXI_AWVALID = 1'b1;
      tick();
      axi.S_AXI_AWVALID = 1'b0;
      check1("mid_aw_taken", axi.S_AXI_AWREADY, 1'b0);
      rst_n = 1'b0;
      #2;
      check32("mid_rst_readys", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd0);
      check1("mid_rst_bvalid", axi.S_AXI_BVALID, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check32("mid_rel_readys", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd7);
      check128("mid_rel_regs", regs_o, 128'd0);
      axi.S_AXI_WDATA = 32'h99; axi.S_AXI_WVALID = 1'b1;
      tick();
      axi.S_AXI_WVALID = 1'b0;
      bad_b = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (axi.S_AXI_BVALID || regs_o != 128'd0 || wr_pulse_o != 4'd0) bad_b++;
      end
      check32("mid_no_commit", bad_b, 32'd0);
      axi.S_AXI_AWADDR = 4'hC; axi.S_AXI_AWVALID = 1'b1;
      tick();
      axi.S_AXI_AWVALID = 1'b0;
      check1("mid_fresh_bvalid", axi.S_AXI_BVALID, 1'b1);
      check32("mid_fresh_reg3", regs_o[127:96], 32'h99);
      check32("mid_fresh_reg0", regs_o[31:0], 32'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_axil_regs.md
AES_AXIL_REGS -- requirements
Module: aes_axil_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, byte-address width (four 32-bit registers).
REQ-003 ACLK  in  1  single clock; all logic is rising-edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  4/3/1/1  write-address channel; AWPROT is ignored.
REQ-006 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write-data channel.
REQ-007 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write-response channel.
REQ-008 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  4/3/1/1  read-address channel; ARPROT is ignored.
REQ-009 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read-data channel.
REQ-010 regs_o  out  128  register contents to user logic; reg0 occupies [31:0] and reg3 occupies [127:96].
REQ-011 wr_pulse_o  out  4  one-cycle strobe per register, asserted on the cycle after that register is committed.

Function
REQ-012 Register map: reg0..reg3 at byte offsets 0x0/0x4/0x8/0xC; address bits [3:2] select the register and bits [1:0] are ignored.
REQ-013 Write path: AW and W are accepted independently; each READY deasserts after its handshake until the B handshake completes, so at most one write is outstanding.
REQ-014 AW and W may arrive in either order or in the same cycle; the address and data are buffered, and the commit occurs on the edge after both are held.
REQ-015 BVALID asserts on the same edge as the commit, with BRESP=OKAY (2'b00); BVALID is held until BREADY, and AWREADY/WREADY reassert on the cycle after the B handshake.
REQ-016 Read path: the AR handshake occurs while ARREADY=1; RDATA is registered and RVALID asserts on the next cycle with RRESP=OKAY; RDATA/RVALID are held stable until RREADY; ARREADY is 0 while RVALID=1.
REQ-017 Write states are W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP; read states are R_IDLE, R_DATA.
REQ-018 When a read samples a register on the same edge that a write commits to it, the read returns the pre-write value.
REQ-019 The read and write paths operate concurrently with no mutual stall.
REQ-020 BREADY or RREADY held low indefinitely stalls only its own path.

Reset
REQ-021 While ARESETN=0: all registers are 0, regs_o=0, wr_pulse_o=0, BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0, AWREADY=WREADY=ARREADY=0, and both FSMs are idle.
REQ-022 AWREADY/WREADY/ARREADY assert on the first ACLK edge after ARESETN deasserts.
REQ-023 Reset asserted mid-transaction discards any buffered address or data and performs no commit.

Configuration
REQ-024 When AES_AXIL_REGS_WSTRB_EN is defined, only the byte lanes with WSTRB[n]=1 are written.
REQ-025 When AES_AXIL_REGS_WSTRB_EN is undefined, WSTRB is ignored and every write updates the full 32-bit word.

Structure
REQ-026 Package aes_axil_pkg holds the RESP_OKAY constant, the NUM_REGS=4 constant, and enums for the write and read state types.
REQ-027 No sub-module is instantiated; the write FSM and read FSM are separate always blocks within aes_axil_regs.

Verification
REQ-028 Write 0x1/0x2/0x3/0x4 to 0x0/0x4/0x8/0xC, then read back in order -> 0x1, 0x2, 0x3, 0x4 with RRESP=0; regs_o=0x00000004_00000003_00000002_00000001.
REQ-029 W presented 3 cycles before AW for data 0xDEADBEEF at 0x8 -> one B response, reg2=0xDEADBEEF, wr_pulse_o=4'b0100 for exactly one cycle.
REQ-030 BREADY held low for 10 cycles -> BVALID stays 1, AWREADY stays 0, and a new AW is not accepted until the B handshake completes.
REQ-031 With WSTRB_EN defined, reg1=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> 0x11BB33DD; with the macro undefined -> 0xAABBCCDD.
REQ-032 Read of 0x4 issued on the same cycle as a committing write of 0x55 to 0x4 (old value 0x2) -> RDATA=0x2; a subsequent read -> 0x55.
REQ-033 ARESETN pulled low after an AW handshake but before W -> no register changes, BVALID=0, and all READYs return to 1 one cycle after release.
